// File: rtl/fpu_pkg.sv
// Shared encodings for the FP issue stage: op codes, per-unit handshake state, unit id.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpu_pkg;

    localparam logic [1:0] FOP_ADD  = 2'd0;
    localparam logic [1:0] FOP_DIV  = 2'd1;
    localparam logic [1:0] FOP_SQRT = 2'd2;
    localparam logic [1:0] FOP_RSVD = 2'd3;

    typedef logic [1:0] unit_id_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_ORDER = 2'd1,
        U_WAIT  = 2'd2,
        U_FULL  = 2'd3
    } ustate_t;

endpackage

// File: rtl/fpu_unit_port.sv
// One FP unit's order/accepted/done handshake with operand, tag and result holding registers.
// Latency: issue -> order next cycle; done -> result held (FULL) next cycle.
// Backpressure: operands held while order waits for accepted; result held in FULL until retired.
module fpu_unit_port
    import fpu_pkg::*;
#(
    parameter int TAGW = 5,
    parameter int OPW  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [OPW-1:0]  issue_ops,
    input  logic [TAGW-1:0] issue_tag,
    input  logic            accepted,
    input  logic            done,
    input  logic [31:0]     rd,
    input  logic            retire,
    output logic            order,
    output logic [OPW-1:0]  ops,
    output logic [31:0]     res,
    output logic [TAGW-1:0] tag,
    output ustate_t         state,
    output logic            spur
);

    ustate_t nxt;
    logic    ld_op;
    logic    ld_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= U_IDLE;
            ops   <= '0;
            res   <= '0;
            tag   <= '0;
        end else begin
            state <= nxt;
            if (ld_op) begin
                ops <= issue_ops;
                tag <= issue_tag;
            end
            if (ld_res) begin
                res <= rd;
            end
        end
    end

    // done is only meaningful in WAIT, or in ORDER when it coincides with accepted
    always_comb begin
        nxt    = state;
        ld_op  = 1'b0;
        ld_res = 1'b0;
        spur   = 1'b0;
        case (state)
            U_IDLE: begin
                spur = done;
                if (issue) begin
                    nxt   = U_ORDER;
                    ld_op = 1'b1;
                end
            end
            U_ORDER: begin
                if (accepted) begin
                    ld_res = done;
                    nxt    = done ? U_FULL : U_WAIT;
                end else begin
                    spur = done;
                end
            end
            U_WAIT: begin
                if (done) begin
                    ld_res = 1'b1;
                    nxt    = U_FULL;
                end
            end
            U_FULL: begin
                spur = done;
                if (retire) begin
                    nxt = U_IDLE;
                end
            end
            default: nxt = U_IDLE;
        endcase
    end

    assign order = (state == U_ORDER);

endmodule

// File: rtl/fpu_dispatch.sv
// In-order FP issue stage: dispatches to fadd/fdiv/fsqrt, returns results in issue order with tag.
// Latency: accept -> order +1 cycle; unit done -> resp_valid +1 cycle when at head.
// Backpressure: req_ready drops when order FIFO full or target unit busy; results held until resp_ready.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [TAGW-1:0] req_tag,
    output logic            add_order,
    output logic            div_order,
    output logic            sqrt_order,
    input  logic            add_accepted,
    input  logic            div_accepted,
    input  logic            sqrt_accepted,
    input  logic            add_done,
    input  logic            div_done,
    input  logic            sqrt_done,
    output logic [31:0]     add_rs1,
    output logic [31:0]     add_rs2,
    output logic [31:0]     div_rs1,
    output logic [31:0]     div_rs2,
    output logic [31:0]     sqrt_rs1,
    input  logic [31:0]     add_rd,
    input  logic [31:0]     div_rd,
    input  logic [31:0]     sqrt_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rd,
    output logic [TAGW-1:0] resp_tag
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    unit_id_t        fifo_mem [DEPTH];
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    unit_id_t        head_id;

    ustate_t         st_add, st_div, st_sqrt;
    logic [31:0]     res_add, res_div, res_sqrt;
    logic [TAGW-1:0] tag_add, tag_div, tag_sqrt;
    logic            spur_add, spur_div, spur_sqrt;
    logic            spurious;
    logic            spurious_unused;

    logic            req_unit_idle;
    logic            head_full;
    logic [31:0]     head_rd;
    logic [TAGW-1:0] head_tag;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_id    = fifo_mem[rd_ptr[PW-1:0]];

    // Reserved op never matches a unit, so it can never be accepted
    always_comb begin
        req_unit_idle = 1'b0;
        case (req_op)
            FOP_ADD:  req_unit_idle = (st_add  == U_IDLE);
            FOP_DIV:  req_unit_idle = (st_div  == U_IDLE);
            FOP_SQRT: req_unit_idle = (st_sqrt == U_IDLE);
            default:  req_unit_idle = 1'b0;
        endcase
    end

    assign req_ready = ~rst & ~fifo_full & req_unit_idle;
    assign push      = req_valid & req_ready;

    always_comb begin
        head_full = 1'b0;
        head_rd   = '0;
        head_tag  = '0;
        case (head_id)
            FOP_ADD:  begin head_full = (st_add  == U_FULL); head_rd = res_add;  head_tag = tag_add;  end
            FOP_DIV:  begin head_full = (st_div  == U_FULL); head_rd = res_div;  head_tag = tag_div;  end
            FOP_SQRT: begin head_full = (st_sqrt == U_FULL); head_rd = res_sqrt; head_tag = tag_sqrt; end
            default:  head_full = 1'b0;
        endcase
    end

    assign resp_valid = ~fifo_empty & head_full;
    assign resp_rd    = resp_valid ? head_rd  : '0;
    assign resp_tag   = resp_valid ? head_tag : '0;
    assign pop        = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            spurious <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PW-1:0]] <= req_op;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (spur_add | spur_div | spur_sqrt) begin
                spurious <= 1'b1;
            end
        end
    end

    // Debug-only sticky flag, observed through hierarchy
    assign spurious_unused = spurious;

    fpu_unit_port #(.TAGW(TAGW), .OPW(64)) u_add (
        .clk       (clk),
        .rst       (rst),
        .issue     (push && (req_op == FOP_ADD)),
        .issue_ops ({req_rs2, req_rs1}),
        .issue_tag (req_tag),
        .accepted  (add_accepted),
        .done      (add_done),
        .rd        (add_rd),
        .retire    (pop && (head_id == FOP_ADD)),
        .order     (add_order),
        .ops       ({add_rs2, add_rs1}),
        .res       (res_add),
        .tag       (tag_add),
        .state     (st_add),
        .spur      (spur_add)
    );

    fpu_unit_port #(.TAGW(TAGW), .OPW(64)) u_div (
        .clk       (clk),
        .rst       (rst),
        .issue     (push && (req_op == FOP_DIV)),
        .issue_ops ({req_rs2, req_rs1}),
        .issue_tag (req_tag),
        .accepted  (div_accepted),
        .done      (div_done),
        .rd        (div_rd),
        .retire    (pop && (head_id == FOP_DIV)),
        .order     (div_order),
        .ops       ({div_rs2, div_rs1}),
        .res       (res_div),
        .tag       (tag_div),
        .state     (st_div),
        .spur      (spur_div)
    );

    fpu_unit_port #(.TAGW(TAGW), .OPW(32)) u_sqrt (
        .clk       (clk),
        .rst       (rst),
        .issue     (push && (req_op == FOP_SQRT)),
        .issue_ops (req_rs1),
        .issue_tag (req_tag),
        .accepted  (sqrt_accepted),
        .done      (sqrt_done),
        .rd        (sqrt_rd),
        .retire    (pop && (head_id == FOP_SQRT)),
        .order     (sqrt_order),
        .ops       (sqrt_rs1),
        .res       (res_sqrt),
        .tag       (tag_sqrt),
        .state     (st_sqrt),
        .spur      (spur_sqrt)
    );

endmodule
